serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 130 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Multi-cycle W-bit adder that reuses one external 4-bit adder slice.
// Operands are walked nibble by nibble, LSB first, and the carry is kept between steps.
`timescale 1ns/1ps
module serial_add_ctrl #(
  parameter int NIBBLES = 4,
  localparam int W  = 4 * NIBBLES,
  localparam int IW = $clog2(NIBBLES)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         slice_en,
  output logic [3:0]   slice_a,
  output logic [3:0]   slice_b,
  output logic         slice_cin,
  input  logic [3:0]   slice_sum,
  input  logic         slice_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;

  logic [IW+1:0]   sh;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic            last_nib;

  // Bit offset of the current nibble inside the operands.
  assign sh       = {idx_q, 2'b00};
  assign a_sh     = a_q >> sh;
  assign b_sh     = b_q >> sh;
  assign last_nib = (idx_q == IW'(NIBBLES - 1));

  assign out_sum  = sum_q;
  assign out_cout = cout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    slice_en  = 1'b0;
    slice_a   = 4'h0;
    slice_b   = 4'h0;
    slice_cin = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Handshake is suppressed during reset so no request is seen as accepted.
        in_ready = ~rst;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        slice_en  = 1'b1;
        slice_a   = a_sh[3:0];
        slice_b   = b_sh[3:0];
        slice_cin = carry_q;
        sum_d     = (sum_q & ~(W'(4'hF) << sh)) | (W'(slice_sum) << sh);
        carry_d   = slice_cout;
        if (last_nib) begin
          cout_d  = slice_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = ~rst;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl with a behavioural 4-bit slice adder.
// Expected sums are queued on acceptance and compared when the result is handed over.
`timescale 1ns/1ps
module tb_serial_add_ctrl;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         slice_en;
  logic [3:0]   slice_a;
  logic [3:0]   slice_b;
  logic         slice_cin;
  logic [3:0]   slice_sum;
  logic         slice_cout;

  serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .slice_en(slice_en), .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_sum(slice_sum), .slice_cout(slice_cout)
  );

  // External slice: plain 4-bit adder with carry.
  assign {slice_cout, slice_sum} = 5'(slice_a) + 5'(slice_b) + 5'(slice_cin);

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [W:0] sb_q[$];
  logic [W:0] exp_v;
  int en_cnt = 0;
  int n_results = 0;
  logic [NIBBLES-1:0] cin_seq = '0;
  logic [NIBBLES-1:0] last_cin_seq = '0;
  logic rnd_rdy = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Monitor: queue on acceptance, compare on output handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      en_cnt = 0;
    end else begin
      if (in_valid && in_ready)
        sb_q.push_back({1'b0, in_a} + {1'b0, in_b} + (W+1)'(in_cin));
      if (slice_en) begin
        if (en_cnt < NIBBLES) cin_seq[en_cnt] = slice_cin;
        en_cnt++;
      end else begin
        chk("slice_idle", 64'({slice_a, slice_b, slice_cin}), 64'd0);
      end
      if (out_valid && out_ready) begin
        chk("slice_en_cycles", 64'(en_cnt), 64'(NIBBLES));
        last_cin_seq = cin_seq;
        en_cnt = 0;
        n_results++;
        if (sb_q.size() == 0) begin
          chk("sb_unexpected", 64'd1, 64'd0);
        end else begin
          exp_v = sb_q.pop_front();
          chk("result", 64'({out_cout, out_sum}), 64'(exp_v));
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bit ok = 1'b0;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    bit ok = 1'b0;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("out_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int lat;
    int n0;
    logic [W-1:0] s_hold;
    logic c_hold;

    // Reset behaviour
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_slice_en", 64'(slice_en), 64'd0);
    chk("post_rst_sum", 64'({out_cout, out_sum}), 64'd0);
    @(posedge clk); #1;

    // Basic add and latency
    send(16'h1234, 16'h4321, 1'b0);
    wait_out(lat);
    chk("latency", 64'(lat), 64'd5);
    tick();
    chk("hold_after_hs_valid", 64'(out_valid), 64'd0);
    chk("hold_after_hs_sum", 64'(out_sum), 64'h5555);

    // Full ripple
    send(16'hFFFF, 16'h0001, 1'b0);
    wait_out(lat);
    tick();
    chk("ripple_cin_seq", 64'(last_cin_seq), 64'b1110);
    chk("ripple_cout", 64'({out_cout, out_sum}), 64'h10000);

    send(16'hFFFF, 16'h0000, 1'b1);
    wait_out(lat);
    tick();
    send(16'h8000, 16'h8000, 1'b0);
    wait_out(lat);
    tick();

    // Back-pressure in DONE while a new request waits
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0);
    wait_out(lat);
    s_hold = out_sum;
    c_hold = out_cout;
    @(posedge clk); #1;
    in_a = 16'h0F0F; in_b = 16'h0101; in_cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_sum", 64'(out_sum), 64'(s_hold));
      chk("bp_cout", 64'(out_cout), 64'(c_hold));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_accept_after", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    tick();

    // Reset in the middle of RUN
    send(16'hAAAA, 16'h5555, 1'b0);
    tick();
    tick();
    chk("mid_slice_a", 64'(slice_a), 64'hA);
    chk("mid_slice_b", 64'(slice_b), 64'h5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_sum", 64'(out_sum), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    send(16'h00FF, 16'h0001, 1'b0);
    wait_out(lat);
    chk("post_mid_sum", 64'({out_cout, out_sum}), 64'h0100);
    tick();

    // Random back-to-back with random back-pressure
    n0 = n_results;
    rnd_rdy = 1'b1;
    for (int t = 0; t < 20; t++)
      send(W'($urandom_range(0, 32'hFFFF)), W'($urandom_range(0, 32'hFFFF)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 3000 && n_results < n0 + 20; i++) @(negedge clk);
    rnd_rdy = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("rand_count", 64'(n_results - n0), 64'd20);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
